// File: rtl/transpose_window_buffer.sv
// Row-to-column transposing shift buffer: keeps the last DEPTH rows of LANES pixels
// and presents them as LANES lanes of DEPTH taps, with fill tracking and backpressure.
module transpose_window_buffer #(
  parameter int PIX_W = 8,
  parameter int LANES = 8,
  parameter int DEPTH = 15,
  parameter int CNT_W = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*PIX_W-1:0]       in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*DEPTH*PIX_W-1:0] out_data,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level,
  output logic [CNT_W-1:0]             win_count
);

  localparam int FW    = $clog2(DEPTH+1);
  localparam int ROW_W = LANES*PIX_W;
  localparam logic [FW:0]   DEPTH_X = (FW+1)'(DEPTH);
  localparam logic [FW-1:0] DEPTH_F = FW'(DEPTH);

  logic [ROW_W-1:0] rows [DEPTH];
  logic             pending;
  logic             acc;
  logic             take;
  logic [FW:0]      fill_inc;

  assign in_ready  = !flush && (!pending || out_ready);
  assign out_valid = pending;
  assign acc       = in_valid && in_ready;
  assign take      = pending && out_ready && !flush;
  // One extra bit so fill_level+1 cannot wrap when DEPTH+1 is a power of two.
  assign fill_inc  = {1'b0, fill_level} + (FW+1)'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < DEPTH; k++) rows[k] <= '0;
      fill_level <= '0;
      pending    <= 1'b0;
      win_count  <= '0;
    end else if (flush) begin
      for (int unsigned k = 0; k < DEPTH; k++) rows[k] <= '0;
      fill_level <= '0;
      pending    <= 1'b0;
    end else begin
      if (acc) begin
        rows[0] <= in_data;
        for (int unsigned k = 1; k < DEPTH; k++) rows[k] <= rows[k-1];
        fill_level <= (fill_inc > DEPTH_X) ? DEPTH_F : fill_inc[FW-1:0];
        pending    <= (fill_inc >= DEPTH_X);
      end else if (take) begin
        pending <= 1'b0;
      end
      if (take) win_count <= win_count + CNT_W'(1);
    end
  end

  always_comb begin
    out_data = '0;
    for (int unsigned j = 0; j < LANES; j++) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        out_data[(j*DEPTH+i)*PIX_W +: PIX_W] = rows[i][j*PIX_W +: PIX_W];
      end
    end
  end

endmodule

// File: tb/tb_transpose_window_buffer.sv
// Bench for transpose_window_buffer: directed scenarios plus random traffic, checked
// against a row-history reference model and a window scoreboard.
module tb_transpose_window_buffer;

  localparam int PIX_W = 8;
  localparam int LANES = 8;
  localparam int DEPTH = 15;
  localparam int CNT_W = 16;
  localparam int FW    = $clog2(DEPTH+1);
  localparam int ROW_W = LANES*PIX_W;
  localparam int OUT_W = LANES*DEPTH*PIX_W;

  logic             clock = 1'b0;
  logic             reset, flush, in_valid, out_ready;
  logic             in_ready, out_valid;
  logic [ROW_W-1:0] in_data;
  logic [OUT_W-1:0] out_data;
  logic [FW-1:0]    fill_level;
  logic [CNT_W-1:0] win_count;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  transpose_window_buffer #(
    .PIX_W(PIX_W),
    .LANES(LANES),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .fill_level(fill_level),
    .win_count(win_count)
  );

  // Reference model: history of accepted rows, newest first, at most DEPTH long.
  logic [ROW_W-1:0] hist[$];
  logic [OUT_W-1:0] exp_q[$];
  bit               m_pend;
  bit               m_rdy;
  bit               m_take;
  int unsigned      m_count;

  function automatic logic [OUT_W-1:0] window_of();
    logic [OUT_W-1:0]       w;
    logic [DEPTH*PIX_W-1:0] lane;
    w = '0;
    for (int j = 0; j < LANES; j++) begin
      lane = '0;
      for (int i = hist.size() - 1; i >= 0; i--)
        lane = (lane << PIX_W) | (DEPTH*PIX_W)'(hist[i][j*PIX_W +: PIX_W]);
      w = w | (OUT_W'(lane) << (j*DEPTH*PIX_W));
    end
    return w;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      hist.delete();
      exp_q.delete();
      m_pend  = 1'b0;
      m_count = 0;
    end else if (flush) begin
      hist.delete();
      exp_q.delete();
      m_pend = 1'b0;
    end else begin
      m_rdy  = !m_pend || out_ready;
      m_take = m_pend && out_ready;
      if (m_take) m_count = (m_count + 1) % (1 << CNT_W);
      if (in_valid && m_rdy) begin
        hist.push_front(in_data);
        if (hist.size() > DEPTH) void'(hist.pop_back());
        if (hist.size() == DEPTH) begin
          m_pend = 1'b1;
          exp_q.push_back(window_of());
        end
      end else if (m_take) begin
        m_pend = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_win(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      for (int k = 0; k < LANES*DEPTH; k++) begin
        if (act[k*PIX_W +: PIX_W] !== exp[k*PIX_W +: PIX_W]) begin
          $display("FAIL %s: lane %0d tap %0d got %0h expected %0h at %0t", name,
                   k / DEPTH, k % DEPTH, act[k*PIX_W +: PIX_W], exp[k*PIX_W +: PIX_W], $time);
          break;
        end
      end
    end
  endtask

  // Every lane must hold taps newest, newest-1, ... (rows filled with pixel = row index).
  task automatic chk_ramp(input string name, input int newest);
    logic [OUT_W-1:0] w;
    w = '0;
    for (int j = 0; j < LANES; j++)
      for (int i = 0; i < DEPTH; i++)
        w[(j*DEPTH+i)*PIX_W +: PIX_W] = PIX_W'(newest - i);
    chk_win(name, out_data, w);
  endtask

  // Monitor: compares every cycle against the model, and pops the scoreboard on each take.
  always @(negedge clock) begin
    if (!reset) begin
      chk("out_valid", 64'(out_valid), 64'(m_pend));
      chk("in_ready", 64'(in_ready), 64'(!flush && (!m_pend || out_ready)));
      chk("fill_level", 64'(fill_level), 64'(hist.size()));
      chk("win_count", 64'(win_count), 64'(m_count));
      chk_win("window_contents", out_data, window_of());
      if (out_valid && out_ready && !flush) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard: window presented got 1 expected 0 at %0t", $time);
        end else begin
          chk_win("scoreboard_window", out_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [ROW_W-1:0] flat_row(input int v);
    logic [ROW_W-1:0] r;
    for (int j = 0; j < LANES; j++) r[j*PIX_W +: PIX_W] = PIX_W'(v);
    return r;
  endfunction

  logic [ROW_W-1:0] trow;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_fill", 64'(fill_level), 64'd0);
    chk("reset_win_count", 64'(win_count), 64'd0);
    chk_win("reset_out_data", out_data, '0);
    #1;

    // Fill with rows 0..14, no consumer.
    for (int r = 0; r < DEPTH; r++) begin
      in_valid = 1'b1;
      in_data  = flat_row(r);
      tick();
      if (r == DEPTH - 2) chk("fill_not_yet_valid", 64'(out_valid), 64'd0);
    end
    chk("fill_out_valid", 64'(out_valid), 64'd1);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    chk_ramp("fill_taps", 14);

    // Backpressure: row 15 offered but blocked for 5 cycles.
    in_data = flat_row(15);
    repeat (5) tick();
    chk("bp_fill", 64'(fill_level), 64'd15);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk_ramp("bp_taps_hold", 14);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk_ramp("bp_taken_taps", 15);
    chk("bp_win_count", 64'(win_count), 64'd1);

    // Sliding: 20 rows back to back, one window per beat.
    out_ready = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      #1 chk("slide_no_bubble", 64'(in_ready), 64'd1);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("slide_win_count", 64'(win_count), 64'd21);

    // Transpose: pixel j = 0x10+j lands on lane j tap 0.
    for (int j = 0; j < LANES; j++) trow[j*PIX_W +: PIX_W] = PIX_W'(8'h10 + j);
    in_data = trow; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    for (int j = 0; j < LANES; j++)
      chk("transpose_tap0", 64'(out_data[(j*DEPTH)*PIX_W +: PIX_W]), 64'(8'h10 + j));
    chk("transpose_win_count", 64'(win_count), 64'd22);

    // Flush mid-fill, refill, then flush while a take is offered.
    flush = 1'b1; tick(); flush = 1'b0;
    for (int r = 0; r < 7; r++) begin
      in_valid = 1'b1; in_data = flat_row(r + 1); tick();
    end
    in_valid = 1'b0;
    chk("preflush_fill", 64'(fill_level), 64'd7);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_fill", 64'(fill_level), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk_win("flush_out_data", out_data, '0);
    for (int r = 0; r < DEPTH; r++) begin
      in_valid = 1'b1; in_data = flat_row(r); tick();
      if (r == DEPTH - 2) chk("refill_not_valid", 64'(out_valid), 64'd0);
    end
    in_valid = 1'b0;
    chk("refill_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1; flush = 1'b1;
    #1 chk("flush_in_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0; out_ready = 1'b0;
    chk("flush_take_win_count", 64'(win_count), 64'd22);
    chk("flush_take_out_valid", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-window.
    for (int r = 0; r < 9; r++) begin
      in_valid = 1'b1; in_data = {$urandom, $urandom}; tick();
    end
    #2 reset = 1'b1;
    #1;
    chk("async_reset_fill", 64'(fill_level), 64'd0);
    chk("async_reset_win_count", 64'(win_count), 64'd0);
    chk_win("async_reset_out_data", out_data, '0);
    tick();
    reset = 1'b0; in_valid = 1'b0;

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      flush     = ($urandom_range(49) == 0);
      in_data   = {$urandom, $urandom};
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
